mem_access_unit: RTL and testbench

//  RV32 memory-stage load/store unit between the EX/MEM register and the MEM/WB register.
//  - Drives a req/ack data-memory bus with byte enables.
//  - Formats load data with sign or zero extension.
//  - Stalls upstream while an access is outstanding.
//  - Presents ALU result, pc+4, load data and writeback control to the MEM/WB register.

---
 rtl/mem_pkg.sv | 50 +++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32 memory-stage load/store unit: funct3 codes,
// writeback-select encodings, FSM states and store-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } memreg_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mau_state_e;

  // Width is carried in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      F3_SH[1:0]: is_misaligned = off[0];
      F3_SW[1:0]: is_misaligned = (off != 2'b00);
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      F3_SB[1:0]: store_be = 4'b0001 << off;
      F3_SH[1:0]: store_be = 4'b0011 << off;
      default:    store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      F3_SB[1:0]: store_wdata = {4{rs2[7:0]}};
      F3_SH[1:0]: store_wdata = {2{rs2[15:0]}};
      default:    store_wdata = rs2;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane select and sign/zero extension for the memory-stage unit.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  data = {24'd0, lane_b};
      F3_LHU:  data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32 memory-stage load/store unit: req/ack data bus, load formatting, upstream stall.
// Optional bus-timeout watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rs2,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_MemR,
  input  logic        ex_MemW,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RegW,
  input  logic [1:0]  ex_MemReg,
  input  logic [31:0] ex_pc_add4,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        valid_out,
  output logic [31:0] alu_out,
  output logic [31:0] pc_add4_out,
  output logic [31:0] dataR_out,
  output logic [4:0]  rd_out,
  output logic        RegW_out,
  output logic [1:0]  MemReg_out
);

  mau_state_e  state_q, state_d;
  logic        is_mem, addr_bad, issue, rsp_load, timeout_hit;
  logic [31:0] load_data;

  assign is_mem   = ex_MemR | ex_MemW;
  assign addr_bad = is_misaligned(ex_funct3, ex_alu[1:0]);

  // EX/MEM is held by mem_stall, so funct3/offset are still valid when the ack lands.
  lsu_load_align u_load_align (
    .funct3 (ex_funct3),
    .offset (ex_alu[1:0]),
    .rdata  (dm_rdata),
    .data   (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // Counter holds the number of BUSY cycles already elapsed without an ack.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_BUSY || state_d != ST_BUSY) wait_cnt_q <= '0;
    else                                                 wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  assign timeout_hit = (state_q == ST_BUSY) && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    rsp_load  = 1'b0;
    mem_stall = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    valid_out = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (ex_valid && is_mem) begin
            if (addr_bad) begin
              misalign  = 1'b1;
              valid_out = 1'b1;
            end else begin
              mem_stall = 1'b1;
              issue     = 1'b1;
              state_d   = ST_BUSY;
            end
          end else begin
            valid_out = ex_valid;
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            valid_out = 1'b1;
            rsp_load  = ex_MemR;
            state_d   = ST_IDLE;
          end else if (timeout_hit) begin
            bus_err   = 1'b1;
            valid_out = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_be    <= 4'b0000;
      dm_addr  <= 32'd0;
      dm_wdata <= 32'd0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        dm_req   <= 1'b1;
        dm_we    <= ex_MemW;
        dm_be    <= store_be(ex_funct3, ex_alu[1:0]);
        dm_addr  <= {ex_alu[31:2], 2'b00};
        dm_wdata <= store_wdata(ex_funct3, ex_rs2);
      end else if (state_q == ST_BUSY && state_d == ST_IDLE) begin
        dm_req <= 1'b0;
      end
    end
  end

  assign alu_out     = rst ? 32'd0 : ex_alu;
  assign pc_add4_out = rst ? 32'd0 : ex_pc_add4;
  assign rd_out      = rst ? 5'd0  : ex_rd;
  assign MemReg_out  = rst ? 2'd0  : ex_MemReg;
  assign dataR_out   = rsp_load ? load_data : 32'd0;
  assign RegW_out    = valid_out & ex_RegW & ~misalign & ~bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table of load/store accesses plus
// hand-written reset, passthrough and timeout/long-wait sequences.
module tb_mem_access_unit;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_MemR, ex_MemW, ex_RegW, dm_ack;
  logic [31:0] ex_alu, ex_rs2, ex_pc_add4, dm_rdata;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_MemReg;
  logic        dm_req, dm_we, mem_stall, misalign, bus_err, valid_out, RegW_out;
  logic [31:0] dm_addr, dm_wdata, alu_out, pc_add4_out, dataR_out;
  logic [3:0]  dm_be;
  logic [4:0]  rd_out;
  logic [1:0]  MemReg_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu(ex_alu), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_MemR(ex_MemR), .ex_MemW(ex_MemW), .ex_rd(ex_rd),
    .ex_RegW(ex_RegW), .ex_MemReg(ex_MemReg), .ex_pc_add4(ex_pc_add4),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .mem_stall(mem_stall),
    .misalign(misalign), .bus_err(bus_err), .valid_out(valid_out), .alu_out(alu_out),
    .pc_add4_out(pc_add4_out), .dataR_out(dataR_out), .rd_out(rd_out),
    .RegW_out(RegW_out), .MemReg_out(MemReg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        rd_op;
    logic        wr_op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_MemR = 1'b0; ex_MemW = 1'b0; ex_RegW = 1'b0;
    ex_alu = 32'd0; ex_rs2 = 32'd0; ex_funct3 = 3'd0; ex_rd = 5'd0;
    ex_MemReg = 2'd0; ex_pc_add4 = 32'd0; dm_rdata = 32'd0; dm_ack = 1'b0;
  endtask

  // Called at posedge+1; presents the instruction in EX/MEM.
  task automatic present(input logic [2:0] f3, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; ex_funct3 = f3; ex_MemR = r; ex_MemW = w;
    ex_alu = a; ex_rs2 = d; ex_rd = 5'd7; ex_RegW = r;
    ex_MemReg = r ? 2'b01 : 2'b00; ex_pc_add4 = a + 32'd4;
  endtask

  task automatic run_vec(input vec_t v);
    int stalls;
    present(v.f3, v.rd_op, v.wr_op, v.addr, v.rs2);
    @(negedge clk);
    if (v.exp_mis) begin
      check({v.name, "_misalign"}, misalign, 1);
      check({v.name, "_stall"}, mem_stall, 0);
      check({v.name, "_valid"}, valid_out, 1);
      check({v.name, "_regw"}, RegW_out, 0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check({v.name, "_noreq"}, dm_req, 0);
      return;
    end
    stalls = 0;
    check({v.name, "_mis0"}, misalign, 0);
    check({v.name, "_idle_valid"}, valid_out, 0);
    if (mem_stall) stalls++;
    for (int i = 0; i < v.waits; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({v.name, "_wait_req"}, dm_req, 1);
      check({v.name, "_wait_valid"}, valid_out, 0);
      if (mem_stall) stalls++;
    end
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = v.rdata;
    @(negedge clk);
    if (mem_stall) stalls++;
    check({v.name, "_stall_cycles"}, stalls, v.waits + 1);
    check({v.name, "_req"}, dm_req, 1);
    check({v.name, "_addr"}, dm_addr, {v.addr[31:2], 2'b00});
    check({v.name, "_we"}, dm_we, v.wr_op);
    if (v.wr_op) begin
      check({v.name, "_be"}, dm_be, v.exp_be);
      check({v.name, "_wdata"}, dm_wdata, v.exp_wdata);
    end
    check({v.name, "_ack_valid"}, valid_out, 1);
    check({v.name, "_data"}, dataR_out, v.exp_data);
    check({v.name, "_regw"}, RegW_out, v.rd_op);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({v.name, "_req_drop"}, dm_req, 0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"lw_100",   3'b010, 1, 0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{"lb_103",   3'b000, 1, 0, 32'h103, 32'h0,        32'h80112233, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{"lbu_103",  3'b100, 1, 0, 32'h103, 32'h0,        32'h80112233, 1, 0, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{"lh_102",   3'b001, 1, 0, 32'h102, 32'h0,        32'h80112233, 0, 0, 4'b1100, 32'h0,        32'hFFFF8011};
    vecs[4]  = '{"lhu_100",  3'b101, 1, 0, 32'h100, 32'h0,        32'h80118233, 0, 0, 4'b0011, 32'h0,        32'h00008233};
    vecs[5]  = '{"lb_101",   3'b000, 1, 0, 32'h101, 32'h0,        32'h80112233, 0, 0, 4'b0010, 32'h0,        32'h00000022};
    vecs[6]  = '{"sh_102",   3'b001, 0, 1, 32'h102, 32'h1234ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[7]  = '{"sb_201",   3'b000, 0, 1, 32'h201, 32'h000000A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{"sw_204",   3'b010, 0, 1, 32'h204, 32'hCAFEF00D, 32'h0,        2, 0, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{"lh_101m",  3'b001, 1, 0, 32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{"sw_206m",  3'b010, 0, 1, 32'h206, 32'h11111111, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{"lw_103m",  3'b010, 1, 0, 32'h103, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};

    idle_inputs();
    rst = 1'b1;
    ex_valid = 1'b1; ex_alu = 32'h55; ex_RegW = 1'b1; ex_rd = 5'd3; ex_pc_add4 = 32'h44;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_regw", RegW_out, 0);
    check("rst_alu", alu_out, 0);
    check("rst_pc4", pc_add4_out, 0);
    check("rst_rd", rd_out, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_req", dm_req, 0);
    check("rst_be", dm_be, 0);
    check("rst_addr", dm_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory op passes straight through.
    present(3'b000, 0, 0, 32'h1234_5678, 32'h0);
    ex_RegW = 1'b1; ex_MemReg = 2'b10; ex_pc_add4 = 32'h0000_2004;
    @(negedge clk);
    check("alu_valid", valid_out, 1);
    check("alu_stall", mem_stall, 0);
    check("alu_regw", RegW_out, 1);
    check("alu_out", alu_out, 32'h1234_5678);
    check("alu_pc4", pc_add4_out, 32'h0000_2004);
    check("alu_memreg", MemReg_out, 2'b10);
    check("alu_rd", rd_out, 5'd7);
    check("alu_dataR", dataR_out, 0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("bubble_valid", valid_out, 0);
    check("bubble_regw", RegW_out, 0);
    @(posedge clk); #1;
    idle_inputs();

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      @(posedge clk); #1;
    end

    // Reset while BUSY aborts the access and a late ack is ignored.
    present(3'b010, 1, 0, 32'h300, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy_req", dm_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_stall", mem_stall, 0);
    check("abort_rst_valid", valid_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("abort_req", dm_req, 0);
    check("abort_stall", mem_stall, 0);
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'h12345678;
    @(negedge clk);
    check("late_ack_valid", valid_out, 0);
    check("late_ack_req", dm_req, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("late_ack_after_req", dm_req, 0);
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    // No ack: bus_err on the TB_TIMEOUT-th BUSY cycle.
    present(3'b010, 1, 0, 32'h400, 32'h0);
    @(posedge clk); #1;
    for (int i = 1; i < TB_TIMEOUT; i++) begin
      @(negedge clk);
      check("to_wait_err", bus_err, 0);
      check("to_wait_stall", mem_stall, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_err", bus_err, 1);
    check("to_valid", valid_out, 1);
    check("to_regw", RegW_out, 0);
    check("to_stall", mem_stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("to_req_drop", dm_req, 0);
    check("to_err_pulse", bus_err, 0);
    @(posedge clk); #1;

    // Ack on the timeout cycle completes normally.
    present(3'b010, 1, 0, 32'h404, 32'h0);
    @(posedge clk); #1;
    for (int i = 1; i < TB_TIMEOUT; i++) begin
      @(posedge clk); #1;
    end
    dm_ack = 1'b1; dm_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("to_ack_err", bus_err, 0);
    check("to_ack_regw", RegW_out, 1);
    check("to_ack_data", dataR_out, 32'h0BADF00D);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("to_ack_req_drop", dm_req, 0);
`else
    // Without the watchdog BUSY waits well past TB_TIMEOUT with no error.
    present(3'b010, 1, 0, 32'h400, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 3 * TB_TIMEOUT; i++) begin
      @(negedge clk);
      check("long_wait_err", bus_err, 0);
      check("long_wait_stall", mem_stall, 1);
      check("long_wait_req", dm_req, 1);
      @(posedge clk); #1;
    end
    dm_ack = 1'b1; dm_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("long_ack_valid", valid_out, 1);
    check("long_ack_data", dataR_out, 32'h0BADF00D);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("long_req_drop", dm_req, 0);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
